// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padder and the SHA-256 core.
//   state_t       : padder FSM states
//   PAD_WORD      : first padding word (the single '1' bit after the message)
//   fifo_entry_t  : one buffered output word with its block position and flags
//   num_blocks()  : number of 16-word blocks needed for an n-word message
package sha256_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MSG   = 2'd1,
    PAD   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        block_last;
    logic        msg_last;
  } fifo_entry_t;

  // The message, the 0x80000000 word and the two length words must fit,
  // so n+3 words are rounded up to a whole number of 16-word blocks.
  function automatic int num_blocks(input int n);
    return (n + 2) / 16 + 1;
  endfunction

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Padded-word stream from the message padder to the SHA-256 core.
//   valid      : data/idx/block_last/msg_last carry a word
//   ready      : consumer accepts the word this cycle
//   data       : padded message word
//   idx        : word position inside the 16-word block
//   block_last : word 15 of a block
//   msg_last   : word 15 of the final block
//
// Handshake: a word transfers on every clock edge where valid && ready.
// Once valid is raised it stays high, and data/idx/block_last/msg_last stay
// unchanged, until that transfer happens. valid never depends
// combinationally on ready.
interface sha256_msg_padder_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic [3:0]  idx;
  logic        block_last;
  logic        msg_last;

  modport master (output valid, data, idx, block_last, msg_last, input ready);
  modport slave  (input  valid, data, idx, block_last, msg_last, output ready);
endinterface

// File: rtl/sha256_word_fifo.sv
// Two-entry FIFO holding padded words on their way to the output stream.
//   clk, reset : clock and synchronous active-high reset (empties the FIFO)
//   push       : write push_data this cycle (caller guarantees space)
//   pop        : remove the head entry this cycle (caller guarantees data)
//   push_data  : entry to write
//   head       : oldest entry, registered, stable until popped
//   count      : number of stored entries (0..2)
module sha256_word_fifo #(
  parameter int W = 38
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/sha256_msg_padder.sv
// Reads a NUM_OF_WORDS-word message from word-addressed memory and streams
// the SHA-256 padded message: message words, 0x80000000, zero fill and the
// 64-bit bit length, grouped in 16-word blocks.
//   clk, reset     : clock, synchronous active-high reset
//   start          : begin a message (only sampled in IDLE)
//   message_addr   : word address of message word 0, latched on start
//   busy, done     : busy while a message is in progress; done pulses once
//   mem_clk/we/addr: memory port (read only); mem_read_data arrives one
//                    cycle after its address
//   out            : padded-word stream (master side)
//   state_dbg      : current FSM state
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [15:0]                 message_addr,
  output logic                        busy,
  output logic                        done,
  output logic                        mem_clk,
  output logic                        mem_we,
  output logic [15:0]                 mem_addr,
  input  logic [31:0]                 mem_read_data,
  sha256_msg_padder_if.master         out,
  output state_t                      state_dbg
);

  localparam int          N      = NUM_OF_WORDS;
  localparam int          NB     = num_blocks(N);
  localparam int          T      = 16 * NB;
  localparam logic [63:0] SIZE   = 64'(N) * 64'd32;
  localparam logic [15:0] K_PAD  = 16'(N);
  localparam logic [15:0] N_LAST = 16'(N - 1);
  localparam logic [15:0] K_HI   = 16'(T - 2);
  localparam logic [15:0] T_LAST = 16'(T - 1);

  state_t      state;
  state_t      next_state;

  logic [15:0] base;
  logic [15:0] rd_k;
  logic [15:0] out_k;
  logic [15:0] addr_q;

  // One-cycle stage that lines generated PAD words up with memory reads:
  // every sourced word (read or generated) is pushed exactly one cycle after
  // it is issued, so a PAD word can never overtake a memory word in flight.
  logic        stage_valid;
  logic        stage_is_mem;
  logic [31:0] stage_word;
  logic [3:0]  stage_idx;
  logic        stage_blast;
  logic        stage_mlast;

  logic [1:0]  fifo_count;
  logic [37:0] fifo_head_bits;
  fifo_entry_t fifo_head;
  fifo_entry_t push_entry;
  logic        pop;
  logic        credit;
  logic        issue;
  logic        read_issue;
  logic        last_hs;
  logic [2:0]  occupancy;
  logic [31:0] pad_word;

  // ---------------------------------------------------------------------------
  // Buffer and credit
  // ---------------------------------------------------------------------------
  assign pop       = out.valid & out.ready;
  // Words already buffered plus the one arriving at this edge, minus the one
  // leaving. Below 2 means a word issued now still has a slot next cycle.
  assign occupancy = 3'(fifo_count) + 3'(stage_valid);
  assign credit    = (occupancy - 3'(pop)) < 3'd2;
  assign issue      = credit && ((state == MSG) || (state == PAD));
  assign read_issue = issue && (state == MSG);
  assign last_hs    = pop && (out_k == T_LAST);

  always_comb begin
    pad_word = 32'd0;
    if (rd_k == K_PAD) begin
      pad_word = PAD_WORD;
    end else if (rd_k == K_HI) begin
      pad_word = SIZE[63:32];
    end else if (rd_k == T_LAST) begin
      pad_word = SIZE[31:0];
    end
  end

  always_comb begin
    push_entry            = '0;
    push_entry.data       = stage_is_mem ? mem_read_data : stage_word;
    push_entry.idx        = stage_idx;
    push_entry.block_last = stage_blast;
    push_entry.msg_last   = stage_mlast;
  end

  sha256_word_fifo #(
    .W ($bits(fifo_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (stage_valid),
    .pop       (pop),
    .push_data (push_entry),
    .head      (fifo_head_bits),
    .count     (fifo_count)
  );

  assign fifo_head      = fifo_head_bits;
  assign out.valid      = (fifo_count != 2'd0);
  assign out.data       = fifo_head.data;
  assign out.idx        = fifo_head.idx;
  assign out.block_last = fifo_head.block_last;
  assign out.msg_last   = fifo_head.msg_last;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start)                         next_state = MSG;
      MSG:   if (read_issue && rd_k == N_LAST)  next_state = PAD;
      PAD:   if (issue && rd_k == T_LAST)       next_state = DRAIN;
      DRAIN: if (last_hs)                       next_state = IDLE;
      default:                                  next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
    mem_we    = 1'b0;
    // The read address is presented in the cycle the read is issued so the
    // first address appears the cycle after start; otherwise it holds.
    mem_addr  = read_issue ? (base + rd_k) : addr_q;
  end

  assign mem_clk = clk;

  // ---------------------------------------------------------------------------
  // Counters, address hold, source stage and done pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      base         <= 16'd0;
      rd_k         <= 16'd0;
      out_k        <= 16'd0;
      addr_q       <= 16'd0;
      stage_valid  <= 1'b0;
      stage_is_mem <= 1'b0;
      stage_word   <= 32'd0;
      stage_idx    <= 4'd0;
      stage_blast  <= 1'b0;
      stage_mlast  <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= (state == DRAIN) && last_hs;

      if ((state == IDLE) && start) begin
        base  <= message_addr;
        rd_k  <= 16'd0;
        out_k <= 16'd0;
      end else begin
        if (issue) rd_k  <= rd_k + 16'd1;
        if (pop)   out_k <= out_k + 16'd1;
      end

      if (read_issue) addr_q <= base + rd_k;

      stage_valid  <= issue;
      stage_is_mem <= (state == MSG);
      stage_word   <= pad_word;
      stage_idx    <= rd_k[3:0];
      stage_blast  <= (rd_k[3:0] == 4'hF);
      stage_mlast  <= (rd_k == T_LAST);
    end
  end

endmodule
